cc_line_serializer: RTL and testbench
=====================================

Name: cc_line_serializer

Overview:
Parametrised cache-line serializer for the cache controller read-return path. It pops one line entry (byte offset + line data) from a first-word-fall-through FIFO and emits the line as LINE_BEATS beats of DATA_W bits, critical word first, with wrap-around. The read channel uses a true valid/ready handshake: data is held until the consumer accepts it, and lines stream back-to-back with no bubble.

Parameters:
DATA_W, 64, beat width in bits; power of two, >= 8
LINE_BEATS, 8, beats per line; power of two, >= 2
OFFSET_W, 6, byte-offset field width; must equal log2(DATA_W/8 * LINE_BEATS)
CRIT_FIRST, 1, 1 = start at the critical beat and wrap; 0 = always start at beat 0

Ports:
clk  in  1  clock
rst  in  1  reset. One clock; reset is synchronous and active-high.
fifo_empty_i  in  1  FIFO empty
fifo_rdata_i  in  OFFSET_W+DATA_W*LINE_BEATS  {byte offset, line}; head entry, valid whenever not empty
fifo_rden_o  out  1  pop strobe; combinational, one cycle per line
rdata_o  out  DATA_W  beat data
rlast_o  out  1  final beat of the line
rvalid_o  out  1  beat valid
rready_i  in  1  consumer ready

Behaviour:
- Beat index b of the line maps to bits [LINE_W-1-b*DATA_W -: DATA_W], where LINE_W = DATA_W*LINE_BEATS; beat 0 is at the MSB.
- Critical beat crit = offset[OFFSET_W-1 : log2(DATA_W/8)]. Low byte-offset bits are ignored.
- Beat k (k = 0..LINE_BEATS-1) emits index (crit+k) mod LINE_BEATS, using log2(LINE_BEATS)-bit wrap arithmetic. With CRIT_FIRST=0, crit is forced to 0.
- State machine states: IDLE, SEND.
- Registers: line_q, crit_q, cnt_q (log2(LINE_BEATS) bits).
- IDLE:
  - rvalid_o=0.
  - If !fifo_empty_i: fifo_rden_o=1; capture line_q and crit_q; cnt_q=0; go to SEND.
  - First beat appears the next cycle (1-cycle latency).
- SEND:
  - rvalid_o=1; rdata_o = line_q beat (crit_q+cnt_q).
  - rlast_o = (cnt_q == LINE_BEATS-1).
  - rdata_o and rlast_o stay stable while rvalid_o && !rready_i.
- Handshake = rvalid_o && rready_i.
  - Handshake on a non-last beat: cnt_q++.
  - Handshake on the last beat with !fifo_empty_i: pop and capture the next line in the same cycle; cnt_q=0; stay in SEND. No idle cycle between lines.
  - Handshake on the last beat with fifo_empty_i: go to IDLE.
- fifo_rden_o is never asserted while fifo_empty_i=1, and never more than once per line.
- fifo_rden_o is 0 in SEND except in the last-beat-handshake cycle.
- rready_i is ignored in IDLE. rvalid_o never deasserts mid-line.
- Reset values: state=IDLE, rvalid_o=0, rlast_o=0, rdata_o=0, fifo_rden_o=0, cnt_q=0, line_q=0.
- Reset mid-line: the partial line is discarded with no rlast_o. The popped entry is not re-read.
- rst overrides everything, including a pop in the same cycle; fifo_rden_o=0 while rst=1.

Optional Feature:
Macro CC_SERIALIZER_RID_EN.
- Defined:
  - New parameter ID_W (default 4).
  - fifo_rdata_i widens to ID_W+OFFSET_W+LINE_W, laid out as {id, offset, line}.
  - id is captured into id_q at pop.
  - New output rid_o (ID_W) = id_q, valid with rvalid_o and stable for all beats of the line. Reset value 0.
- Undefined: no ID bits, no rid_o; port widths exactly as listed above.

Test Plan:
- Defaults, entry offset=6'h00, beats D0..D7 (D0 at MSB), rready_i=1 -> pop in cycle N; beats D0..D7 in N+1..N+8; rlast_o only at N+8; then IDLE.
- Offset=6'h2B (crit=5), rready_i=1 -> order D5,D6,D7,D0,D1,D2,D3,D4; rlast_o on D4.
- rready_i=0 on cycles 2 and 3 of the line -> rvalid_o stays 1 with the same rdata_o; the line completes in 10 cycles; no beat dropped or duplicated.
- Two entries queued, rready_i=1 -> 16 consecutive valid beats; fifo_rden_o pulses at N and N+8 only; rlast_o at N+8 and N+16.
- rst=1 after 3 beats with a second entry waiting -> next cycle rvalid_o=0 and fifo_rden_o=0; after release, the second entry streams from beat 0 of its order.
- CRIT_FIRST=0 with offset=6'h38 -> order D0..D7. With CC_SERIALIZER_RID_EN and id=4'hA -> rid_o=4'hA on all 8 beats.

Source files
------------

// File: rtl/cc_line_serializer_if.sv
// Handshake bundle for cc_line_serializer: FIFO pop side plus beat read channel.
// Optional macro CC_SERIALIZER_RID_EN adds an id field to the entry and a rid_o output.
interface cc_line_serializer_if #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned LINE_BEATS = 8,
   parameter int unsigned OFFSET_W   = 6
`ifdef CC_SERIALIZER_RID_EN
   ,
   parameter int unsigned ID_W       = 4
`endif
);
`ifdef CC_SERIALIZER_RID_EN
   localparam int unsigned ENTRY_W = ID_W + OFFSET_W + DATA_W * LINE_BEATS;
`else
   localparam int unsigned ENTRY_W = OFFSET_W + DATA_W * LINE_BEATS;
`endif

   logic               fifo_empty_i;
   logic [ENTRY_W-1:0] fifo_rdata_i;
   logic               fifo_rden_o;
   logic [DATA_W-1:0]  rdata_o;
   logic               rlast_o;
   logic               rvalid_o;
   logic               rready_i;
`ifdef CC_SERIALIZER_RID_EN
   logic [ID_W-1:0]    rid_o;
`endif

   modport master (
      input  fifo_empty_i, fifo_rdata_i, rready_i,
      output fifo_rden_o, rdata_o, rlast_o, rvalid_o
`ifdef CC_SERIALIZER_RID_EN
      , rid_o
`endif
   );

   modport slave (
      output fifo_empty_i, fifo_rdata_i, rready_i,
      input  fifo_rden_o, rdata_o, rlast_o, rvalid_o
`ifdef CC_SERIALIZER_RID_EN
      , rid_o
`endif
   );
endinterface

// File: rtl/cc_line_serializer.sv
// Pops one {offset, line} entry from a FWFT FIFO and streams it as LINE_BEATS beats,
// critical word first with wrap. Macro CC_SERIALIZER_RID_EN adds {id} capture and rid_o.
module cc_line_serializer #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned LINE_BEATS = 8,
   parameter int unsigned OFFSET_W   = 6,
   parameter int unsigned CRIT_FIRST = 1
`ifdef CC_SERIALIZER_RID_EN
   ,
   parameter int unsigned ID_W       = 4
`endif
) (
   input logic                  clk,
   input logic                  rst,
   cc_line_serializer_if.master bus
);
   localparam int unsigned LINE_W = DATA_W * LINE_BEATS;
   localparam int unsigned BEAT_W = $clog2(LINE_BEATS);
   localparam int unsigned BYTE_W = $clog2(DATA_W / 8);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [BEAT_W-1:0]   crit_q, crit_d;
   logic [BEAT_W-1:0]   cnt_q, cnt_d;
   logic [BEAT_W-1:0]   beat_idx;
   logic [DATA_W-1:0]   beat_data;
   logic [LINE_W-1:0]   line_in;
   logic [OFFSET_W-1:0] offset_in;
   logic                pop, last, handshake;
   logic                unused_offset;

   assign line_in   = bus.fifo_rdata_i[LINE_W-1:0];
   assign offset_in = bus.fifo_rdata_i[LINE_W +: OFFSET_W];
   // Sub-beat byte bits never select anything.
   assign unused_offset = ^offset_in;

`ifdef CC_SERIALIZER_RID_EN
   logic [ID_W-1:0] id_q, id_d;
   assign bus.rid_o = id_q;
`endif

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      crit_d    = crit_q;
      cnt_d     = cnt_q;
      pop       = 1'b0;
      last      = (state_q == StSend) && (cnt_q == BEAT_W'(LINE_BEATS - 1));
      handshake = (state_q == StSend) && bus.rready_i;
`ifdef CC_SERIALIZER_RID_EN
      id_d      = id_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!bus.fifo_empty_i) begin
               pop     = 1'b1;
               state_d = StSend;
            end
         end
         StSend: begin
            if (handshake) begin
               if (!last) begin
                  cnt_d = cnt_q + BEAT_W'(1);
               end else if (!bus.fifo_empty_i) begin
                  pop = 1'b1;  // back-to-back line, no idle cycle
               end else begin
                  state_d = StIdle;
               end
            end
         end
      endcase
      if (pop) begin
         line_d = line_in;
         crit_d = (CRIT_FIRST != 0) ? offset_in[OFFSET_W-1:BYTE_W] : '0;
         cnt_d  = '0;
`ifdef CC_SERIALIZER_RID_EN
         id_d   = bus.fifo_rdata_i[LINE_W+OFFSET_W +: ID_W];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         line_q  <= '0;
         crit_q  <= '0;
         cnt_q   <= '0;
`ifdef CC_SERIALIZER_RID_EN
         id_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         crit_q  <= crit_d;
         cnt_q   <= cnt_d;
`ifdef CC_SERIALIZER_RID_EN
         id_q    <= id_d;
`endif
      end
   end

   // Beat 0 sits at the MSB end of the line.
   assign beat_idx = crit_q + cnt_q;
   always_comb begin
      beat_data = '0;
      for (int unsigned b = 0; b < LINE_BEATS; b++) begin
         if (beat_idx == BEAT_W'(b)) begin
            beat_data = line_q[LINE_W-1-b*DATA_W -: DATA_W];
         end
      end
   end

   assign bus.fifo_rden_o = pop & ~rst;
   assign bus.rvalid_o    = (state_q == StSend);
   assign bus.rlast_o     = last;
   assign bus.rdata_o     = beat_data;
endmodule

// File: tb/tb_cc_line_serializer.sv
// Directed bench for cc_line_serializer: one CRIT_FIRST=1 and one CRIT_FIRST=0 instance
// share the same FIFO model and consumer; expected beat orders are hand-written nibble tables.
module tb_cc_line_serializer;
`ifdef CC_SERIALIZER_RID_EN
   localparam int unsigned ENTRY_W = 4 + 6 + 512;
`else
   localparam int unsigned ENTRY_W = 6 + 512;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               rready = 1'b1;
   logic               fifo_empty = 1'b1;
   logic [ENTRY_W-1:0] fifo_rdata = '0;
   logic [ENTRY_W-1:0] q[$];
   bit                 pop_seen = 1'b0;
   int                 n_checks = 0;
   int                 n_errors = 0;

   always #5 clk = ~clk;

   cc_line_serializer_if bus_a ();
   cc_line_serializer_if bus_b ();

   assign bus_a.fifo_empty_i = fifo_empty;
   assign bus_a.fifo_rdata_i = fifo_rdata;
   assign bus_a.rready_i     = rready;
   assign bus_b.fifo_empty_i = fifo_empty;
   assign bus_b.fifo_rdata_i = fifo_rdata;
   assign bus_b.rready_i     = rready;

   cc_line_serializer u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   cc_line_serializer #(
      .CRIT_FIRST (0)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   function automatic logic [63:0] beat_val(input logic [7:0] tag, input int b);
      return {tag, 8'(b), 48'hC0FF_EE12_3456};
   endfunction

   function automatic logic [ENTRY_W-1:0] make_entry(input logic [7:0] tag, input logic [5:0] off);
      logic [511:0] line;
      for (int b = 0; b < 8; b++) line[511-b*64 -: 64] = beat_val(tag, b);
`ifdef CC_SERIALIZER_RID_EN
      return {tag[3:0], off, line};
`else
      return {off, line};
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and let outputs settle before returning.
   task automatic step(input logic r, input logic rdy);
      @(negedge clk);
      if (pop_seen && q.size() > 0) q.delete(0);
      rst        = r;
      rready     = rdy;
      fifo_empty = (q.size() == 0);
      fifo_rdata = fifo_empty ? '0 : q[0];
      #1;
      pop_seen = bus_a.fifo_rden_o;
   endtask

   // ord holds the expected beat index for beat k in nibble 7-k.
   task automatic expect_line(input string name, input logic [7:0] tag, input logic [31:0] ord,
                              input int nbeats, input bit next_pop);
      int idx;
      for (int k = 0; k < nbeats; k++) begin
         idx = int'(ord[31-4*k -: 4]);
         step(1'b0, 1'b1);
         check_eq($sformatf("%s.valid%0d", name, k), 64'(bus_a.rvalid_o), 64'd1);
         check_eq($sformatf("%s.data%0d", name, k), bus_a.rdata_o, beat_val(tag, idx));
         check_eq($sformatf("%s.last%0d", name, k), 64'(bus_a.rlast_o), 64'(k == 7));
         check_eq($sformatf("%s.rden%0d", name, k), 64'(bus_a.fifo_rden_o),
                  64'((k == 7) && next_pop));
         check_eq($sformatf("%s.b_data%0d", name, k), bus_b.rdata_o, beat_val(tag, k));
`ifdef CC_SERIALIZER_RID_EN
         check_eq($sformatf("%s.rid%0d", name, k), 64'(bus_a.rid_o), 64'(tag[3:0]));
`endif
      end
   endtask

   task automatic expect_idle(input string name);
      step(1'b0, 1'b1);
      check_eq({name, ".idle_valid"}, 64'(bus_a.rvalid_o), 64'd0);
      check_eq({name, ".idle_rden"}, 64'(bus_a.fifo_rden_o), 64'd0);
      check_eq({name, ".idle_last"}, 64'(bus_a.rlast_o), 64'd0);
   endtask

   task automatic expect_pop(input string name);
      step(1'b0, 1'b1);
      check_eq({name, ".pop_rden"}, 64'(bus_a.fifo_rden_o), 64'd1);
      check_eq({name, ".pop_valid"}, 64'(bus_a.rvalid_o), 64'd0);
   endtask

   initial begin
      // Reset state
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check_eq("rst.valid", 64'(bus_a.rvalid_o), 64'd0);
      check_eq("rst.last", 64'(bus_a.rlast_o), 64'd0);
      check_eq("rst.data", bus_a.rdata_o, 64'd0);
      check_eq("rst.rden", 64'(bus_a.fifo_rden_o), 64'd0);
      expect_idle("rst");

      // Offset 0: natural order
      q.push_back(make_entry(8'h11, 6'h00));
      expect_pop("off00");
      expect_line("off00", 8'h11, 32'h0123_4567, 8, 1'b0);
      expect_idle("off00");

      // Offset 0x2B: critical beat 5, wrap
      q.push_back(make_entry(8'h22, 6'h2B));
      expect_pop("off2b");
      expect_line("off2b", 8'h22, 32'h5670_1234, 8, 1'b0);
      expect_idle("off2b");

      // Back-pressure on line cycles 2 and 3
      q.push_back(make_entry(8'h33, 6'h00));
      expect_pop("stall");
      step(1'b0, 1'b1);
      check_eq("stall.d0", bus_a.rdata_o, beat_val(8'h33, 0));
      for (int c = 0; c < 2; c++) begin
         step(1'b0, 1'b0);
         check_eq($sformatf("stall.hold_valid%0d", c), 64'(bus_a.rvalid_o), 64'd1);
         check_eq($sformatf("stall.hold_data%0d", c), bus_a.rdata_o, beat_val(8'h33, 1));
         check_eq($sformatf("stall.hold_last%0d", c), 64'(bus_a.rlast_o), 64'd0);
      end
      for (int k = 1; k < 8; k++) begin
         step(1'b0, 1'b1);
         check_eq($sformatf("stall.data%0d", k), bus_a.rdata_o, beat_val(8'h33, k));
         check_eq($sformatf("stall.last%0d", k), 64'(bus_a.rlast_o), 64'(k == 7));
      end
      expect_idle("stall");

      // Two queued lines stream back to back
      q.push_back(make_entry(8'h44, 6'h00));
      q.push_back(make_entry(8'h55, 6'h10));
      expect_pop("b2b");
      expect_line("b2b_first", 8'h44, 32'h0123_4567, 8, 1'b1);
      expect_line("b2b_second", 8'h55, 32'h2345_6701, 8, 1'b0);
      expect_idle("b2b");

      // Reset after three beats with a second entry waiting
      q.push_back(make_entry(8'h66, 6'h00));
      q.push_back(make_entry(8'h77, 6'h08));
      expect_pop("mrst");
      expect_line("mrst_part", 8'h66, 32'h0123_4567, 3, 1'b0);
      step(1'b1, 1'b1);
      check_eq("mrst.rden_in_rst", 64'(bus_a.fifo_rden_o), 64'd0);
      step(1'b1, 1'b1);
      check_eq("mrst.valid", 64'(bus_a.rvalid_o), 64'd0);
      check_eq("mrst.last", 64'(bus_a.rlast_o), 64'd0);
      check_eq("mrst.rden_held", 64'(bus_a.fifo_rden_o), 64'd0);
      expect_pop("mrst_next");
      expect_line("mrst_next", 8'h77, 32'h1234_5670, 8, 1'b0);
      expect_idle("mrst");

      // Offset 0x38: instance A starts at beat 7, instance B (no critical-first) at 0
      q.push_back(make_entry(8'h9A, 6'h38));
      expect_pop("off38");
      expect_line("off38", 8'h9A, 32'h7012_3456, 8, 1'b0);
      expect_idle("off38");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
